// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects ALU/load/FPU result, commits it to the x or f register file,
// counts commits and flags dual-file write requests. Define WB_BYPASS_EN for write-through reads.
module wb_stage_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int CW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] alu_result_wb,
    input  logic [XLEN-1:0] mem_rdata_wb,
    input  logic [XLEN-1:0] fpu_result_wb,
    input  logic [AW-1:0]   rd_wb,
    input  logic            reg_write_wb,
    input  logic            mem_to_reg_wb,
    input  logic            fp_op_wb,
    input  logic            fp_reg_write_wb,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   frs1_addr,
    input  logic [AW-1:0]   frs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] frs1_data,
    output logic [XLEN-1:0] frs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic [CW-1:0]   wb_count,
    output logic            wb_conflict
);

    logic [XLEN-1:0] x_q  [1:NREG-1];
    logic [XLEN-1:0] x_rd [NREG];
    logic [XLEN-1:0] f_q  [NREG];
    logic [CW-1:0]   wb_count_q, wb_count_d;
    logic            wb_conflict_q, wb_conflict_d;
    logic            int_we, fp_we;

    always_comb begin
        if (mem_to_reg_wb)
            wb_data = mem_rdata_wb;
        else if (fp_reg_write_wb | fp_op_wb)
            wb_data = fpu_result_wb;
        else
            wb_data = alu_result_wb;
    end

    // FP write wins a dual-file request; x0 writes are dropped entirely
    assign fp_we  = fp_reg_write_wb;
    assign int_we = reg_write_wb & ~fp_reg_write_wb & (rd_wb != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_regs
            if (gi == 0) begin : g_x0
                assign x_rd[gi] = '0;
            end else begin : g_xn
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        x_q[gi] <= '0;
                    else if (int_we && rd_wb == AW'(gi))
                        x_q[gi] <= wb_data;
                end
                assign x_rd[gi] = x_q[gi];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    f_q[gi] <= '0;
                else if (fp_we && rd_wb == AW'(gi))
                    f_q[gi] <= wb_data;
            end
        end
    endgenerate

    assign wb_count_d    = wb_count_q + CW'(int_we | fp_we);
    assign wb_conflict_d = wb_conflict_q | (reg_write_wb & fp_reg_write_wb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_count_q    <= '0;
            wb_conflict_q <= 1'b0;
        end else begin
            wb_count_q    <= wb_count_d;
            wb_conflict_q <= wb_conflict_d;
        end
    end

    assign wb_count    = wb_count_q;
    assign wb_conflict = wb_conflict_q;

    always_comb begin
        rs1_data  = x_rd[rs1_addr];
        rs2_data  = x_rd[rs2_addr];
        frs1_data = f_q[frs1_addr];
        frs2_data = f_q[frs2_addr];
`ifdef WB_BYPASS_EN
        // int_we already excludes x0 and conflicts, so it gates the bypass too
        if (int_we && rs1_addr == rd_wb)  rs1_data  = wb_data;
        if (int_we && rs2_addr == rd_wb)  rs2_data  = wb_data;
        if (fp_we  && frs1_addr == rd_wb) frs1_data = wb_data;
        if (fp_we  && frs2_addr == rd_wb) frs2_data = wb_data;
`endif
    end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile: driver pushes model expectations, negedge monitor checks.
module tb_wb_stage_regfile;

    localparam int CW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] alu_result_wb = '0, mem_rdata_wb = '0, fpu_result_wb = '0;
    logic [4:0]  rd_wb = '0;
    logic        reg_write_wb = 1'b0, mem_to_reg_wb = 1'b0, fp_op_wb = 1'b0, fp_reg_write_wb = 1'b0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, frs1_addr = '0, frs2_addr = '0;
    logic [31:0] rs1_data, rs2_data, frs1_data, frs2_data, wb_data;
    logic [CW-1:0] wb_count;
    logic        wb_conflict;

    wb_stage_regfile #(.XLEN(32), .NREG(32), .AW(5), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result_wb(alu_result_wb), .mem_rdata_wb(mem_rdata_wb), .fpu_result_wb(fpu_result_wb),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .mem_to_reg_wb(mem_to_reg_wb),
        .fp_op_wb(fp_op_wb), .fp_reg_write_wb(fp_reg_write_wb),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .frs1_addr(frs1_addr), .frs2_addr(frs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .frs1_data(frs1_data), .frs2_data(frs2_data),
        .wb_data(wb_data), .wb_count(wb_count), .wb_conflict(wb_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu, mem, fpu;
        logic [4:0]  rd;
        logic        rw, m2r, fpop, fpw;
        logic [4:0]  a1, a2, fa1, fa2;
    } txn_t;

    typedef struct {
        int          id;
        logic [31:0] rs1, rs2, frs1, frs2, wbd;
        logic [31:0] cnt;
        logic        conf;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int txn_id = 0;

    // Reference state: architectural register contents and counters
    logic [31:0] xm [32];
    logic [31:0] fm [32];
    int          commits;
    logic        conf_m;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            xm[i] = '0;
            fm[i] = '0;
        end
        commits = 0;
        conf_m  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s txn %0d: got %h expected %h", name, txn_id, act, exp);
        end
    endtask

    task automatic issue(input txn_t t);
        exp_t        e;
        logic [31:0] wbv;
        logic        xw;
        @(posedge clk);
        #1;
        alu_result_wb = t.alu; mem_rdata_wb = t.mem; fpu_result_wb = t.fpu;
        rd_wb = t.rd; reg_write_wb = t.rw; mem_to_reg_wb = t.m2r;
        fp_op_wb = t.fpop; fp_reg_write_wb = t.fpw;
        rs1_addr = t.a1; rs2_addr = t.a2; frs1_addr = t.fa1; frs2_addr = t.fa2;

        wbv = t.m2r ? t.mem : ((t.fpw || t.fpop) ? t.fpu : t.alu);
        xw  = t.rw && !t.fpw && (t.rd != 0);
        e.id   = txn_id;
        e.wbd  = wbv;
        e.rs1  = (t.a1 == 0) ? 32'd0 : xm[t.a1];
        e.rs2  = (t.a2 == 0) ? 32'd0 : xm[t.a2];
        e.frs1 = fm[t.fa1];
        e.frs2 = fm[t.fa2];
`ifdef WB_BYPASS_EN
        if (xw && t.a1 == t.rd)   e.rs1  = wbv;
        if (xw && t.a2 == t.rd)   e.rs2  = wbv;
        if (t.fpw && t.fa1 == t.rd) e.frs1 = wbv;
        if (t.fpw && t.fa2 == t.rd) e.frs2 = wbv;
`endif
        e.cnt  = 32'(commits % (1 << CW));
        e.conf = conf_m;
        sb.push_back(e);
        txn_id++;

        if (xw)    xm[t.rd] = wbv;
        if (t.fpw) fm[t.rd] = wbv;
        if (xw || t.fpw) commits++;
        if (t.rw && t.fpw) conf_m = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rs1_data",    rs1_data,  e.rs1);
            chk("rs2_data",    rs2_data,  e.rs2);
            chk("frs1_data",   frs1_data, e.frs1);
            chk("frs2_data",   frs2_data, e.frs2);
            chk("wb_data",     wb_data,   e.wbd);
            chk("wb_count",    32'(wb_count), e.cnt);
            chk("wb_conflict", {31'd0, wb_conflict}, {31'd0, e.conf});
            $display("txn %0d rd=%0d wb=%h cnt=%0d conf=%0b", e.id, rd_wb, wb_data, wb_count, wb_conflict);
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        #1;
    endtask

    function automatic txn_t blank();
        txn_t t;
        t = '{alu: '0, mem: '0, fpu: '0, rd: '0, rw: 1'b0, m2r: 1'b0, fpop: 1'b0, fpw: 1'b0,
              a1: '0, a2: '0, fa1: '0, fa2: '0};
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.alu = $urandom; t.mem = $urandom; t.fpu = $urandom;
        t.rd   = 5'($urandom_range(0, 31));
        t.rw   = ($urandom_range(0, 1) == 1);
        t.fpw  = ($urandom_range(0, 9) < 3);
        t.m2r  = ($urandom_range(0, 3) == 0);
        t.fpop = ($urandom_range(0, 4) == 0);
        t.a1  = 5'($urandom_range(0, 31));
        t.a2  = ($urandom_range(0, 2) == 0) ? t.rd : 5'($urandom_range(0, 31));
        t.fa1 = 5'($urandom_range(0, 31));
        t.fa2 = ($urandom_range(0, 2) == 0) ? t.rd : 5'($urandom_range(0, 31));
        return t;
    endfunction

    task automatic reset_check();
        drain();
        @(posedge clk);
        #1;
        // a write presented during reset must not land
        alu_result_wb = 32'hDEAD_BEEF; rd_wb = 5'd3; reg_write_wb = 1'b1;
        fp_reg_write_wb = 1'b0; mem_to_reg_wb = 1'b0; fp_op_wb = 1'b0;
        rs1_addr = 5'd3; frs1_addr = 5'd7;
        rst_n = 1'b0;
        #1;
        chk("reset wb_count",    32'(wb_count), 32'd0);
        chk("reset wb_conflict", {31'd0, wb_conflict}, 32'd0);
        chk("reset frs1_data",   frs1_data, 32'd0);
        @(posedge clk);
        #1;
        chk("reset x3 held", rs1_data, 32'd0);
        reg_write_wb = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        txn_t t;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // every index of both files reads zero after reset
        for (int i = 0; i < 32; i++) begin
            t = blank();
            t.a1 = 5'(i); t.a2 = 5'(31 - i); t.fa1 = 5'(i); t.fa2 = 5'(31 - i);
            issue(t);
        end

        t = blank(); t.alu = 32'h1234_5678; t.rd = 5'd5; t.rw = 1'b1; issue(t);
        t = blank(); t.a1 = 5'd5; issue(t);
        t = blank(); t.alu = 32'hFFFF_FFFF; t.rd = 5'd0; t.rw = 1'b1; issue(t);
        t = blank(); t.a1 = 5'd0; issue(t);
        t = blank(); t.m2r = 1'b1; t.fpw = 1'b1; t.mem = 32'h3F80_0000; t.rd = 5'd0; issue(t);
        t = blank(); t.fa1 = 5'd0; t.a1 = 5'd0; t.a2 = 5'd5; issue(t);
        t = blank(); t.alu = 32'h0707_0707; t.rd = 5'd7; t.rw = 1'b1; issue(t);
        t = blank(); t.rw = 1'b1; t.fpw = 1'b1; t.rd = 5'd7; t.fpu = 32'hC000_0000; issue(t);
        t = blank(); t.a1 = 5'd7; t.fa1 = 5'd7; issue(t);
        t = blank(); t.alu = 32'h1111_1111; t.rd = 5'd9; t.rw = 1'b1; issue(t);
        t = blank(); t.alu = 32'hA5A5_A5A5; t.rd = 5'd9; t.rw = 1'b1; t.a2 = 5'd9; issue(t);
        t = blank(); t.a1 = 5'd9; t.a2 = 5'd9; issue(t);

        for (int i = 0; i < 450; i++) issue(rand_txn());
        t = blank(); issue(t);

        reset_check();

        for (int i = 0; i < 150; i++) begin
            t = rand_txn();
            if (t.fpw) t.rw = 1'b0;
            issue(t);
        end
        t = blank(); issue(t);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
